// File: rtl/kamikaze_decode_pkg.sv
// Shared definitions for the kamikaze decode stage: RV32I major opcodes,
// immediate formats and the decoded-instruction record held in the D/E register.
package kamikaze_defs;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [1:0] QUAD_32BIT   = 2'b11;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] link_pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [4:0]  opcode;
      logic [2:0]  fun3;
      logic        alt;
      logic        rd_write;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        illegal;
   } dec_t;

   function automatic imm_fmt_e imm_fmt(input logic [4:0] opc);
      imm_fmt_e fmt;
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
         OPC_STORE:                                  fmt = IMM_S;
         OPC_BRANCH:                                 fmt = IMM_B;
         OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
         OPC_JAL:                                    fmt = IMM_J;
         default:                                    fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/kamikaze_decode_imm.sv
// Immediate extraction for a 32-bit RV32I instruction word; purely combinational.
module kamikaze_decode_imm
   import kamikaze_defs::*;
(
   input  logic [31:0] ir_i,
   output logic [31:0] imm_o
);

   imm_fmt_e fmt;

   // Words that are not 32-bit encodings carry no immediate.
   always_comb begin
      fmt = IMM_NONE;
      if (ir_i[1:0] == QUAD_32BIT) begin
         fmt = imm_fmt(ir_i[6:2]);
      end
   end

   always_comb begin
      imm_o = '0;
      case (fmt)
         IMM_I:   imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
         IMM_S:   imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
         IMM_B:   imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
         IMM_U:   imm_o = {ir_i[31:12], 12'b0};
         IMM_J:   imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/kamikaze_decode.sv
// RV32I decode stage: decodes the fetch word into the D/E pipeline register,
// detects load-use hazards and stalls fetch.
module kamikaze_decode
   import kamikaze_defs::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        f_valid_i,
   input  logic [31:0] f_ir_i,
   input  logic [31:0] f_pc_i,
   input  logic        f_is_compressed_i,
   output logic        f_stall_o,
   input  logic        d_stall_i,
   input  logic        d_kill_i,
   output logic [4:0]  rf_rs1_o,
   output logic [4:0]  rf_rs2_o,
   output logic        d_valid_o,
   output logic [31:0] d_pc_o,
   output logic [31:0] d_ir_o,
   output logic [31:0] d_link_pc_o,
   output logic [4:0]  d_rs1_o,
   output logic [4:0]  d_rs2_o,
   output logic [4:0]  d_rd_o,
   output logic [4:0]  d_opcode_o,
   output logic [2:0]  d_fun3_o,
   output logic        d_alt_o,
   output logic [31:0] d_imm_o,
   output logic        d_rd_write_o,
   output logic        d_is_load_o,
   output logic        d_is_store_o,
   output logic        d_is_branch_o,
   output logic        d_is_jal_o,
   output logic        d_is_jalr_o,
   output logic        d_illegal_o
);

   dec_t        dec_q, dec_d, dec_new;
   logic        valid_q, valid_d;
   logic [31:0] imm;
   logic [4:0]  opc;
   logic        quad_ok;
   logic        uses_rs1, uses_rs2;
   logic        hz;

   kamikaze_decode_imm u_imm (
      .ir_i  (f_ir_i),
      .imm_o (imm)
   );

   assign rf_rs1_o = f_ir_i[19:15];
   assign rf_rs2_o = f_ir_i[24:20];

   assign opc     = f_ir_i[6:2];
   assign quad_ok = (f_ir_i[1:0] == QUAD_32BIT);

   always_comb begin
      dec_new           = '0;
      dec_new.pc        = f_pc_i;
      dec_new.ir        = f_ir_i;
      dec_new.link_pc   = f_pc_i + (f_is_compressed_i ? 32'd2 : 32'd4);
      dec_new.imm       = imm;
      dec_new.rs1       = f_ir_i[19:15];
      dec_new.rs2       = f_ir_i[24:20];
      dec_new.rd        = f_ir_i[11:7];
      dec_new.opcode    = opc;
      dec_new.fun3      = f_ir_i[14:12];
      dec_new.alt       = f_ir_i[30];
      dec_new.is_load   = quad_ok & (opc == OPC_LOAD);
      dec_new.is_store  = quad_ok & (opc == OPC_STORE);
      dec_new.is_branch = quad_ok & (opc == OPC_BRANCH);
      dec_new.is_jal    = quad_ok & (opc == OPC_JAL);
      dec_new.is_jalr   = quad_ok & (opc == OPC_JALR);
      dec_new.rd_write  = (f_ir_i[11:7] != 5'd0) & ~dec_new.is_store & ~dec_new.is_branch;
      dec_new.illegal   = ~quad_ok |
                          ~(opc inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                                        OPC_MISC_MEM, OPC_SYSTEM});
   end

   // Source-use is judged on the major opcode alone, so an illegal word can still interlock.
   always_comb begin
      uses_rs1 = ~(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
      uses_rs2 = opc inside {OPC_STORE, OPC_BRANCH, OPC_OP};
      hz = valid_q & dec_q.is_load & (dec_q.rd != 5'd0) & f_valid_i &
           ((uses_rs1 & (f_ir_i[19:15] == dec_q.rd)) |
            (uses_rs2 & (f_ir_i[24:20] == dec_q.rd)));
   end

   assign f_stall_o = d_stall_i | hz;

   always_comb begin
      valid_d = valid_q;
      dec_d   = dec_q;
      if (d_kill_i) begin
         valid_d = 1'b0;
      end else if (!d_stall_i) begin
         if (hz) begin
            valid_d = 1'b0;
         end else begin
            valid_d = f_valid_i;
            dec_d   = dec_new;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dec_q   <= dec_d;
      end
   end

   assign d_valid_o     = valid_q;
   assign d_pc_o        = dec_q.pc;
   assign d_ir_o        = dec_q.ir;
   assign d_link_pc_o   = dec_q.link_pc;
   assign d_rs1_o       = dec_q.rs1;
   assign d_rs2_o       = dec_q.rs2;
   assign d_rd_o        = dec_q.rd;
   assign d_opcode_o    = dec_q.opcode;
   assign d_fun3_o      = dec_q.fun3;
   assign d_alt_o       = dec_q.alt;
   assign d_imm_o       = dec_q.imm;
   assign d_rd_write_o  = dec_q.rd_write;
   assign d_is_load_o   = dec_q.is_load;
   assign d_is_store_o  = dec_q.is_store;
   assign d_is_branch_o = dec_q.is_branch;
   assign d_is_jal_o    = dec_q.is_jal;
   assign d_is_jalr_o   = dec_q.is_jalr;
   assign d_illegal_o   = dec_q.illegal;

endmodule
